// File: rtl/reduce_stream.sv
// reduce_stream: folds the operand beats of a packet with AND/OR/XOR into one result word.
// Optional feature: define REDUCE_STREAM_XOR_EN to build XOR for mode 2'b10 (otherwise mode 2'b10 folds as AND).

module reduce_stream #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 8,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_bit,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic             trunc_q, trunc_d;
  logic [CW-1:0]    count_inc;

  // Mode 2'b11, and 2'b10 when XOR is not built, fall into the AND arm.
  function automatic logic [WIDTH-1:0] fold(input logic [1:0] m,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (m)
      2'b01:   r = a | b;
`ifdef REDUCE_STREAM_XOR_EN
      2'b10:   r = a ^ b;
`endif
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic reduce_bit(input logic [1:0] m, input logic [WIDTH-1:0] a);
    logic r;
    case (m)
      2'b01:   r = |a;
`ifdef REDUCE_STREAM_XOR_EN
      2'b10:   r = ^a;
`endif
      default: r = &a;
    endcase
    return r;
  endfunction

  assign count_inc = count_q + CW'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    trunc_d = trunc_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          count_d = CW'(1);
          mode_d  = mode;
          trunc_d = 1'b0;
          state_d = in_last ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d   = fold(mode_q, acc_q, in_data);
          count_d = count_inc;
          if (in_last) begin
            state_d = S_HOLD;
          end else if (count_inc == CW'(MAX_BEATS)) begin
            trunc_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Overflow beats are swallowed; only in_last matters here.
        if (in_valid && in_last) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset as well, because the result outputs must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 2'b00;
      trunc_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      trunc_q <= trunc_d;
    end
  end

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = acc_q;
  assign out_bit   = reduce_bit(mode_q, acc_q);
  assign out_count = count_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_reduce_stream.sv
// Self-checking bench for reduce_stream: a packet-level reference model checked every cycle,
// directed packets with literal expectations, then randomized packets with random backpressure.

module tb_reduce_stream;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 8;
  localparam int CW        = $clog2(MAX_BEATS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_bit;
  logic [CW-1:0]    out_count;
  logic             out_trunc;

  int checks = 0;
  int errors = 0;

  reduce_stream #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bit   (out_bit),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    if (m == 2'b01) return a | b;
`ifdef REDUCE_STREAM_XOR_EN
    if (m == 2'b10) return a ^ b;
`endif
    return a & b;
  endfunction

  function automatic logic ref_bit(input logic [1:0] m, input logic [7:0] a);
    if (m == 2'b01) return |a;
`ifdef REDUCE_STREAM_XOR_EN
    if (m == 2'b10) return ^a;
`endif
    return &a;
  endfunction

  bit         pending = 1'b0;
  logic [7:0] beats[$];
  logic [1:0] pkt_mode;
  logic [7:0] exp_data;
  logic       exp_bit;
  int         exp_count;
  logic       exp_trunc;

  // Packet-level view: collect every accepted beat, and on the terminating beat fold the
  // first min(n, MAX_BEATS) operands; the packet is truncated when n exceeds MAX_BEATS.
  always @(posedge clk) begin
    int n, k;
    logic [7:0] a;
    if (!rst_n) begin
      pending = 1'b0;
      beats.delete();
    end else if (pending) begin
      if (out_ready) pending = 1'b0;
    end else if (in_valid) begin
      if (beats.size() == 0) pkt_mode = mode;
      beats.push_back(in_data);
      if (in_last) begin
        n = beats.size();
        k = (n < MAX_BEATS) ? n : MAX_BEATS;
        a = beats[0];
        for (int i = 1; i < k; i++) a = ref_op(pkt_mode, a, beats[i]);
        exp_data  = a;
        exp_bit   = ref_bit(pkt_mode, a);
        exp_count = k;
        exp_trunc = (n > MAX_BEATS);
        pending   = 1'b1;
        beats.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !pending);
      check("out_valid", out_valid, pending);
      if (pending) begin
        check("out_data", out_data, exp_data);
        check("out_bit", out_bit, exp_bit);
        check("out_count", out_count, exp_count);
        check("out_trunc", out_trunc, exp_trunc);
      end
    end
  end

  // ---------------- drivers ----------------
  logic rdy_force_en  = 1'b1;
  logic rdy_force_val = 1'b0;

  always @(posedge clk) begin
    #1;
    out_ready = rdy_force_en ? rdy_force_val : ($urandom_range(0, 3) != 0);
  end

  task automatic set_ready(input logic en, input logic val);
    rdy_force_en  = en;
    rdy_force_val = val;
    if (en) out_ready = val;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic [1:0] m);
    logic rdy;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    mode     = m;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_accept actual=not_accepted expected=accepted at %0t", $time);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
    mode     = 2'($urandom);
  endtask

  // Called right after the terminating beat was accepted, with out_ready held low.
  task automatic expect_result(input string tag, input logic [7:0] d, input logic b,
                               input int cnt, input logic tr);
    check({tag, "_latency"}, out_valid, 1'b1);
    @(negedge clk);
    check({tag, "_data"}, out_data, d);
    check({tag, "_bit"}, out_bit, b);
    check({tag, "_count"}, out_count, cnt);
    check({tag, "_trunc"}, out_trunc, tr);
    set_ready(1'b1, 1'b1);
    @(posedge clk);
    #1;
    check({tag, "_released"}, out_valid, 1'b0);
    set_ready(1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    mode      = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_bit", out_bit, 1'b0);
    check("rst_out_count", out_count, 0);
    check("rst_out_trunc", out_trunc, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    idle_cycle();

    // AND of eight 8'h01 beats, last on the MAX_BEATS boundary: not truncated.
    set_ready(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) beat(8'h01, i == 7, (i == 0) ? 2'b00 : 2'($urandom));
    expect_result("and8", 8'h01, 1'b0, 8, 1'b0);

    // OR of three beats.
    beat(8'h01, 1'b0, 2'b01);
    beat(8'h10, 1'b0, 2'b00);
    beat(8'h80, 1'b1, 2'b10);
    expect_result("or3", 8'h91, 1'b1, 3, 1'b0);

    // Mode 2'b10 depends on whether XOR is built.
    beat(8'hFF, 1'b0, 2'b10);
    beat(8'h0F, 1'b1, 2'b01);
`ifdef REDUCE_STREAM_XOR_EN
    expect_result("xor2", 8'hF0, 1'b0, 2, 1'b0);
`else
    expect_result("xor2", 8'h0F, 1'b0, 2, 1'b0);
`endif

    // Ten beats: beats 9 and 10 are drained, result frozen at eight operands.
    for (int i = 0; i < 10; i++) beat(i < 8 ? 8'hFF : 8'h00, i == 9, (i == 0) ? 2'b00 : 2'b01);
    expect_result("trunc", 8'hFF, 1'b1, 8, 1'b1);
    beat(8'h12, 1'b0, 2'b01);
    beat(8'h34, 1'b1, 2'b00);
    expect_result("after_trunc", 8'h36, 1'b1, 2, 1'b0);

    // Single beat held under backpressure for five cycles.
    beat(8'hA5, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_data", out_data, 8'hA5);
      check("hold_count", out_count, 1);
    end
    @(posedge clk);
    #1;
    expect_result("single", 8'hA5, 1'b0, 1, 1'b0);

    // Reset in the middle of a packet.
    beat(8'h11, 1'b0, 2'b00);
    beat(8'h22, 1'b0, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_count", out_count, 0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(8'h3C, 1'b1, 2'b00);
    expect_result("post_rst", 8'h3C, 1'b0, 1, 1'b0);

    // Reset while a result is being held drops out_valid immediately.
    beat(8'h5A, 1'b1, 2'b01);
    check("holdrst_pre_valid", out_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("holdrst_out_valid", out_valid, 1'b0);
    check("holdrst_out_trunc", out_trunc, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized packets with random backpressure, mode noise on later beats and idle gaps.
    set_ready(1'b0, 1'b0);
    for (int p = 0; p < 250; p++) begin
      int         len;
      logic [1:0] m;
      logic [7:0] d;
      len = $urandom_range(1, 12);
      m   = 2'($urandom);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) idle_cycle();
        end
        case ($urandom_range(0, 3))
          0:       d = 8'hFF;
          1:       d = 8'($urandom) | 8'hE7;
          2:       d = 8'($urandom) & 8'h18;
          default: d = 8'($urandom);
        endcase
        beat(d, i == len - 1, (i == 0) ? m : 2'($urandom));
      end
    end

    set_ready(1'b1, 1'b1);
    repeat (3) idle_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reduce_stream.md
REDUCE_STREAM -- requirements
Module: reduce_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits (>=1).
REQ-002 The block SHALL have parameter MAX_BEATS, default 8, maximum operands per packet (>=2); CW = ceil(log2(MAX_BEATS+1)).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid  input  1  operand beat valid.
REQ-006 The block SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 The block SHALL have port in_data  input  WIDTH  operand.
REQ-008 The block SHALL have port in_last  input  1  final beat of packet.
REQ-009 The block SHALL have port mode  input  2  00 AND, 01 OR, 10 XOR, 11 reserved (treated as AND).
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 The block SHALL have port out_data  output  WIDTH  bitwise reduction of all packet operands.
REQ-013 The block SHALL have port out_bit  output  1  out_data reduced to one bit with the packet's operator.
REQ-014 The block SHALL have port out_count  output  CW  operands folded into out_data.
REQ-015 The block SHALL have port out_trunc  output  1  packet ended by MAX_BEATS, not in_last.

Function
REQ-016 The FSM SHALL have states IDLE, ACC, HOLD, DRAIN; in_ready=1 in IDLE/ACC/DRAIN, 0 in HOLD.
REQ-017 The first beat accepted in IDLE SHALL load acc=in_data and count=1, and latch mode for the whole packet; mode is ignored on later beats.
REQ-018 Each later accepted beat in ACC SHALL set acc=op(acc,in_data) and count=count+1.
REQ-019 An accepted beat with in_last=1 SHALL move to HOLD next cycle, with out_trunc=0 and the final result including that beat.
REQ-020 An accepted beat without in_last that makes count==MAX_BEATS SHALL move to DRAIN with out_trunc=1 and the result frozen.
REQ-021 DRAIN SHALL accept and discard beats without accumulating; the accepted beat with in_last=1 SHALL move to HOLD.
REQ-022 If in_last coincides with count reaching MAX_BEATS, the block SHALL go to HOLD with out_trunc=0.
REQ-023 out_valid SHALL be 1 exactly in HOLD; out_data/out_bit/out_count/out_trunc SHALL stay stable while out_valid && !out_ready.
REQ-024 out_valid && out_ready SHALL return the FSM to IDLE next cycle; no input beat is accepted in that cycle.
REQ-025 Latency SHALL be one cycle from acceptance of the terminating beat to out_valid=1 (with out_trunc=1, out_valid rises one cycle after the in_last beat accepted in DRAIN).
REQ-026 A single-beat packet SHALL give out_data=in_data and out_count=1.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, out_valid=0, out_data=0, out_bit=0, out_count=0, out_trunc=0, acc=0.
REQ-028 Reset mid-packet SHALL discard the partial packet; the first beat after release starts a new packet.

Configuration
REQ-029 With macro REDUCE_STREAM_XOR_EN defined, mode 10 SHALL perform XOR (out_bit = parity of out_data); undefined, mode 10 SHALL behave as AND and no XOR logic is built.

Verification
REQ-030 AND, 8 beats 8'h01, in_last on beat 8 -> out_data 8'h01, out_bit 0, out_count 8, out_trunc 0.
REQ-031 OR, beats 8'h01, 8'h10, 8'h80(last) -> out_data 8'h91, out_bit 1, out_count 3.
REQ-032 mode 10, beats 8'hFF, 8'h0F(last) -> with macro out_data 8'hF0, out_bit 0; without macro out_data 8'h0F, out_bit 0.
REQ-033 AND, 10 beats 8'hFF, last on beat 10 -> out_data 8'hFF, out_count 8, out_trunc 1 after beat 10; beats 9-10 discarded; next packet unaffected.
REQ-034 Single beat 8'hA5(last), out_ready held 0 for 5 cycles -> outputs stable, in_ready 0 throughout; then out_data 8'hA5, out_count 1.
REQ-035 rst_n pulsed low after 2 beats of a packet -> out_valid 0 at once; next packet 8'h3C(last) yields out_data 8'h3C, out_count 1.
